// File: rtl/btn_debounce_hold_pkg.sv
// Shared types and sizing helpers for the button debounce/hold slice.
package btn_debounce_hold_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_DOWN      = 2'd2,
    ST_DISARMING = 2'd3
  } btn_state_t;

  function automatic int unsigned tick_div(input int unsigned clk_freq_hz);
    return (clk_freq_hz < 1000) ? 1 : clk_freq_hz / 1000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_hold_if.sv
// Button-side signals: raw level in, conditioned level and hold pulses out.
interface btn_debounce_hold_if;
  logic btn_raw;
  logic btn_clean;
  logic long_press;
  logic repeat_pulse;

  modport master (output btn_raw, input btn_clean, input long_press, input repeat_pulse);
  modport slave  (input btn_raw, output btn_clean, output long_press, output repeat_pulse);
endinterface

// File: rtl/tick_gen_1ms.sv
// Free-running 1 ms prescaler: tick is high for one clk every CLK_FREQ_HZ/1000 clk.
module tick_gen_1ms
  import btn_debounce_hold_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int unsigned DIV = tick_div(CLK_FREQ_HZ);
  localparam int unsigned CW  = cnt_width(DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)            r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/btn_debounce_hold.sv
// Push-button conditioner: 2-FF synchroniser, tick-sampled debounce FSM,
// long-press pulse and periodic repeat pulses while held.
module btn_debounce_hold
  import btn_debounce_hold_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
  parameter int unsigned DEBOUNCE_MS   = 10,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter int unsigned REPEAT_MS     = 200
) (
  input  logic                      clk,
  input  logic                      reset_p,
  btn_debounce_hold_if.slave        btn_if
);

  localparam int unsigned HOLD_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int unsigned DW = cnt_width(DEBOUNCE_MS);
  localparam int unsigned HW = cnt_width(HOLD_MAX);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_PRESS_MS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_MS - 1);

  logic          w_tick;
  logic          r_sync1;
  logic          r_sync2;
  btn_state_t    r_state;
  logic [DW-1:0] r_deb_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_held;
  logic          r_btn_clean;
  logic          r_long_press;
  logic          r_repeat_pulse;

  tick_gen_1ms #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (w_tick)
  );

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_if.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state        <= ST_IDLE;
      r_deb_cnt      <= '0;
      r_hold_cnt     <= '0;
      r_held         <= 1'b0;
      r_btn_clean    <= 1'b0;
      r_long_press   <= 1'b0;
      r_repeat_pulse <= 1'b0;
    end else begin
      r_long_press   <= 1'b0;
      r_repeat_pulse <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          ST_IDLE: begin
            if (r_sync2) begin
              if (DEBOUNCE_MS == 1) begin
                r_state     <= ST_DOWN;
                r_btn_clean <= 1'b1;
                r_hold_cnt  <= '0;
                r_held      <= 1'b0;
                r_deb_cnt   <= '0;
              end else begin
                r_state   <= ST_ARMING;
                r_deb_cnt <= DW'(1);
              end
            end
          end
          ST_ARMING: begin
            if (!r_sync2) begin
              r_state   <= ST_IDLE;
              r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
              r_state     <= ST_DOWN;
              r_btn_clean <= 1'b1;
              r_hold_cnt  <= '0;
              r_held      <= 1'b0;
              r_deb_cnt   <= '0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end
          ST_DOWN: begin
            if (r_sync2) begin
              // hold_cnt is reused: first times the long press, then each repeat period
              if (!r_held) begin
                if (r_hold_cnt == LONG_LAST) begin
                  r_long_press <= 1'b1;
                  r_held       <= 1'b1;
                  r_hold_cnt   <= '0;
                end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
                end
              end else if (r_hold_cnt == REP_LAST) begin
                r_repeat_pulse <= 1'b1;
                r_hold_cnt     <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end else if (DEBOUNCE_MS == 1) begin
              r_state     <= ST_IDLE;
              r_btn_clean <= 1'b0;
              r_hold_cnt  <= '0;
              r_held      <= 1'b0;
            end else begin
              r_state   <= ST_DISARMING;
              r_deb_cnt <= DW'(1);
            end
          end
          ST_DISARMING: begin
            if (r_sync2) begin
              r_state   <= ST_DOWN;
              r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
              r_state     <= ST_IDLE;
              r_btn_clean <= 1'b0;
              r_hold_cnt  <= '0;
              r_held      <= 1'b0;
              r_deb_cnt   <= '0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign btn_if.btn_clean    = r_btn_clean;
  assign btn_if.long_press   = r_long_press;
  assign btn_if.repeat_pulse = r_repeat_pulse;

endmodule

// File: tb/tb_btn_debounce_hold.sv
// Scoreboard bench for btn_debounce_hold: expected output events (tick-stamped) are
// queued as stimulus is planned and popped as the DUT produces edges/pulses.
module tb_btn_debounce_hold;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_LONG = 2;
  localparam int EV_REP  = 3;

  typedef struct {
    int kind;
    int tick;
  } ev_t;

  logic clk;
  logic reset_p;
  int   n_checks;
  int   n_fail;
  int   g_tick;
  int   r_div;
  logic r_prev_clean;
  ev_t  exp_q[$];

  btn_debounce_hold_if u_if ();

  btn_debounce_hold #(
    .CLK_FREQ_HZ   (10_000),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (20),
    .REPEAT_MS     (5)
  ) u_dut (
    .clk     (clk),
    .reset_p (reset_p),
    .btn_if  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench time base: a 1 ms tick lands on every 10th clk edge after reset release.
  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_div <= 0;
    end else if (r_div == 9) begin
      r_div  <= 0;
      g_tick <= g_tick + 1;
    end else begin
      r_div <= r_div + 1;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, tick %0d)", tag, obs, exp, $time, g_tick);
    end
  endtask

  task automatic push_ev(input int kind, input int tick);
    ev_t e;
    e.kind = kind;
    e.tick = tick;
    exp_q.push_back(e);
  endtask

  task automatic record_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check_eq("event_kind", kind, e.kind);
      check_eq("event_tick", g_tick, e.tick);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_p) begin
      if (u_if.btn_clean !== r_prev_clean)
        record_ev(u_if.btn_clean ? EV_RISE : EV_FALL);
      if (u_if.long_press === 1'b1)   record_ev(EV_LONG);
      if (u_if.repeat_pulse === 1'b1) record_ev(EV_REP);
    end
    r_prev_clean <= u_if.btn_clean;
  end

  // Returns 2 time units after the negedge following the next tick edge.
  task automatic wait_tick();
    int t0;
    int guard;
    t0 = g_tick;
    guard = 0;
    while (g_tick == t0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (g_tick == t0) check_eq("tick_timeout", g_tick - t0, 1);
    #2;
  endtask

  task automatic step(input logic v, input int n);
    u_if.btn_raw = v;
    repeat (n) wait_tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, pending events %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    n_checks     = 0;
    n_fail       = 0;
    g_tick       = 0;
    r_prev_clean = 1'b0;
    reset_p      = 1'b1;
    u_if.btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_btn_clean", int'(u_if.btn_clean), 0);
    check_eq("reset_long_press", int'(u_if.long_press), 0);
    check_eq("reset_repeat_pulse", int'(u_if.repeat_pulse), 0);
    #2 reset_p = 1'b0;

    // 1: clean press / release, no pulses
    wait_tick();
    t = g_tick;
    push_ev(EV_RISE, t + 4);
    push_ev(EV_FALL, t + 14);
    step(1'b1, 10);
    step(1'b0, 10);
    check_eq("sc1_pending", exp_q.size(), 0);

    // 2: bouncing press qualifies only after the last low sample
    wait_tick();
    t = g_tick;
    push_ev(EV_RISE, t + 8);
    push_ev(EV_FALL, t + 16);
    step(1'b1, 1);
    step(1'b0, 1);
    step(1'b1, 1);
    step(1'b0, 1);
    step(1'b1, 8);
    step(1'b0, 10);
    check_eq("sc2_pending", exp_q.size(), 0);

    // 3: long hold with repeats; release suppresses further pulses
    wait_tick();
    t = g_tick;
    push_ev(EV_RISE, t + 4);
    push_ev(EV_LONG, t + 24);
    for (int m = 1; m <= 6; m++) push_ev(EV_REP, t + 24 + 5 * m);
    push_ev(EV_FALL, t + 58);
    step(1'b1, 54);
    step(1'b0, 10);
    check_eq("sc3_pending", exp_q.size(), 0);

    // 4: 2-tick release gap after long press freezes the repeat timer
    wait_tick();
    t = g_tick;
    push_ev(EV_RISE, t + 4);
    push_ev(EV_LONG, t + 24);
    push_ev(EV_REP, t + 29);
    push_ev(EV_REP, t + 37);
    push_ev(EV_REP, t + 42);
    push_ev(EV_FALL, t + 46);
    step(1'b1, 30);
    step(1'b0, 2);
    step(1'b1, 10);
    step(1'b0, 10);
    check_eq("sc4_pending", exp_q.size(), 0);

    // 5: async reset mid-hold, button still held afterwards
    wait_tick();
    t = g_tick;
    push_ev(EV_RISE, t + 4);
    step(1'b1, 19);
    reset_p = 1'b1;
    #1;
    check_eq("sc5_reset_btn_clean", int'(u_if.btn_clean), 0);
    check_eq("sc5_reset_long_press", int'(u_if.long_press), 0);
    check_eq("sc5_reset_repeat_pulse", int'(u_if.repeat_pulse), 0);
    repeat (3) @(negedge clk);
    #2 reset_p = 1'b0;
    t = g_tick;
    push_ev(EV_RISE, t + 4);
    push_ev(EV_LONG, t + 24);
    push_ev(EV_FALL, t + 28);
    step(1'b1, 24);
    step(1'b0, 10);
    check_eq("sc5_pending", exp_q.size(), 0);

    // 6: sub-tick pulse and 3-tick pulse are both rejected
    wait_tick();
    u_if.btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    #2 u_if.btn_raw = 1'b0;
    wait_tick();
    step(1'b1, 3);
    step(1'b0, 10);
    check_eq("sc6_pending", exp_q.size(), 0);
    check_eq("sc6_btn_clean", int'(u_if.btn_clean), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
